// File: rtl/prog_freq_div.sv
// Programmable square-wave divider.
// The output level lasts `act` clk cycles, timed by a down-counter that
// reloads at each boundary (en=1 and cnt==0). A new divisor loaded while
// running waits in a shadow register until the level in progress has
// finished, so a level is never cut short or stretched. With en low a new
// divisor takes effect immediately. A load of zero is rejected and flagged
// on err for one cycle.
module prog_freq_div #(
    parameter int W           = 9,
    parameter int DEFAULT_DIV = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] div_in,
    output logic         out,
    output logic         tick,
    output logic         pend,
    output logic         err
);

    localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);
    localparam logic [W-1:0] ONE     = W'(1);

    logic [W-1:0] act_q, act_d;
    logic [W-1:0] shd_q, shd_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         out_q, out_d;
    logic         tick_q, tick_d;
    logic         pend_q, pend_d;
    logic         err_q, err_d;

    logic         load_ok;
    logic         load_bad;
    logic         boundary;

    // Classify this cycle's load request and detect a half-period boundary.
    always_comb begin
        load_ok  = load && (div_in != '0);
        load_bad = load && (div_in == '0);
        boundary = en && (cnt_q == '0);
    end

    // Next-state logic: counter, divisor selection, output toggle and flags.
    always_comb begin
        act_d  = act_q;
        shd_d  = shd_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        pend_d = pend_q;
        tick_d = 1'b0;
        err_d  = load_bad;

        if (!en) begin
            // Idle: a valid load replaces the divisor right away and
            // supersedes anything still waiting in the shadow register.
            if (load_ok) begin
                act_d  = div_in;
                cnt_d  = div_in - ONE;
                pend_d = 1'b0;
            end
        end else if (boundary) begin
            out_d  = ~out_q;
            tick_d = 1'b1;
            if (load_ok) begin
                // A load landing on the boundary wins over any older shadow value.
                act_d  = div_in;
                cnt_d  = div_in - ONE;
                pend_d = 1'b0;
            end else if (pend_q) begin
                act_d  = shd_q;
                cnt_d  = shd_q - ONE;
                pend_d = 1'b0;
            end else begin
                cnt_d  = act_q - ONE;
            end
        end else begin
            // Mid-level: keep counting; park a new divisor until the boundary.
            cnt_d = cnt_q - ONE;
            if (load_ok) begin
                shd_d  = div_in;
                pend_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_q  <= DEF_DIV;
            shd_q  <= DEF_DIV;
            cnt_q  <= DEF_DIV - ONE;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            act_q  <= act_d;
            shd_q  <= shd_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            tick_q <= tick_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        out  = out_q;
        tick = tick_q;
        pend = pend_q;
        err  = err_q;
    end

endmodule
